countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
//  Sequencer for the keypad-set countdown timer. Decodes keypad key events into a 2-digit minute entry.
//  Drives the clock counter via load/load_minute/pause and monitors it for 00:00.
//  Selects what the 4-digit display shows and drives the external switch (relay).
//  Sits between keypad3c4r/clock/num2decs and display5461AS1 in the timer top level.
// PARAMETERS
//  MAX_MINUTE    7'd99  upper clip for load_minute; entries above it load MAX_MINUTE
//  DONE_TIMEOUT  6'd30  ticks spent in DONE before automatic return to IDLE; 0 = never
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  tick_1hz     in   1   one-clk-wide enable pulse, once per second
//  key_valid    in   1   one-clk pulse per debounced key press
//  key          in   4   key code when key_valid: 0-9 digit, 10 '*', 11 '#'; 12-15 ignored
//  minute       in   7   clock counter minutes (binary)
//  second       in   6   clock counter seconds (binary)
//  clock_hexx   in   16  BCD mm:ss of clock counter, {m_t,m_o,s_t,s_o}
//  load         out  1   one-clk pulse: clock loads load_minute:00
//  load_minute  out  7   binary minute value for load; held stable except during pulse setup
//  pause        out  1   1 = clock counter frozen
//  switch       out  1   1 = relay on (counting)
//  hexx         out  16  BCD value to display
//  disp_en      out  1   display enable (blink control)
//  points       out  4   decimal points; 4'b0100 in all states
// BEHAVIOUR
//  Reset: state IDLE, entry=8'h00, load=0, load_minute=0, pause=1, switch=0, hexx=16'h0000, disp_en=1, armed=0, tmo=0.
//  States: IDLE, ENTRY, RUN, PAUSE, DONE. Only key_valid cycles with key 0-11 are events.
//  IDLE: digit d -> entry={4'h0,d}, go ENTRY. '*' and '#' ignored.
//  ENTRY: digit d -> entry={entry[3:0],d} (old tens digit dropped). '*' -> entry=0, IDLE.
//   '#': if entry==0 ignored; else load=1 for exactly one clk with
//   load_minute=min(tens*10+ones, MAX_MINUTE), pause=0, switch=1, armed=0, go RUN.
//  RUN: armed<=1 on any cycle with {minute,second}!=0. If armed and minute==0 and second==0 -> DONE (pause=1, switch=0, tmo=0).
//   '#' -> PAUSE (pause=1, switch=0). '*' -> IDLE: load pulse with load_minute=0, entry=0, pause=1, switch=0.
//   Same-cycle '*' and zero detect: '*' wins. Same-cycle '#' and zero detect: DONE wins.
//  PAUSE: '#' -> RUN (pause=0, switch=1, armed kept). '*' -> IDLE as from RUN. digits ignored.
//  DONE: any valid key -> IDLE, entry=0. tmo increments on tick_1hz.
//   If DONE_TIMEOUT!=0 and tmo reaches DONE_TIMEOUT -> IDLE.
//  hexx: IDLE/ENTRY = {entry,8'h00}; RUN/PAUSE/DONE = clock_hexx, registered (1 clk latency).
//  disp_en: 1 in IDLE/ENTRY/RUN; in PAUSE toggles on each tick_1hz, forced 1 on PAUSE exit.
//  All outputs registered. Key event to state/output change: 1 clk. Mid-operation rst aborts to reset values within one clk; no load pulse issued.
// CONFIGURATION
//  DONE_BLINK_EN defined: in DONE, disp_en toggles on each tick_1hz (starting 0 on entry), forced 1 on exit.
//  DONE_BLINK_EN undefined: disp_en=1 steady in DONE; display shows 00:00 constantly.
// TESTING
//  rst, keys 2,5,'#' -> load pulse 1 clk with load_minute=25, pause=0, switch=1, hexx=clock_hexx.
//  keys 1,2,3,'#' -> entry 8'h23, load_minute=23; keys 9,9 with MAX_MINUTE=60 -> load_minute=60.
//  RUN, then model counts to 00:00 -> DONE next clk, switch=0, pause=1; 30 ticks later IDLE (DONE_TIMEOUT=30).
//  RUN '#' -> pause=1, disp_en toggles per tick; '#' -> pause=0, disp_en=1; '*' -> load with load_minute=0, IDLE.
//  RUN: zero detect and '*' in same clk -> IDLE. '#' in ENTRY with entry 00 ignored. Key 14 ignored in every state.
//  rst asserted in RUN -> next clk all outputs at reset values, load=0.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Keypad countdown-timer sequencer: minute entry, clock load/pause control, display and relay drive.
// Optional macro DONE_BLINK_EN: blink the display while in DONE.
module countdown_ctrl #(
   parameter logic [6:0] MAX_MINUTE   = 7'd99,
   parameter logic [5:0] DONE_TIMEOUT = 6'd30
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        tick_1hz_i,
   input  logic        key_valid_i,
   input  logic [3:0]  key_i,
   input  logic [6:0]  minute_i,
   input  logic [5:0]  second_i,
   input  logic [15:0] clock_hexx_i,
   output logic        load_o,
   output logic [6:0]  load_minute_o,
   output logic        pause_o,
   output logic        switch_o,
   output logic [15:0] hexx_o,
   output logic        disp_en_o,
   output logic [3:0]  points_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  entry_q, entry_d;
   logic        load_q, load_d;
   logic [6:0]  load_minute_q, load_minute_d;
   logic        pause_q, pause_d;
   logic        switch_q, switch_d;
   logic [15:0] hexx_q, hexx_d;
   logic        disp_en_q, disp_en_d;
   logic        armed_q, armed_d;
   logic [5:0]  tmo_q, tmo_d;
   logic [3:0]  points_q;

   logic        key_ev_s, is_digit_s, is_star_s, is_hash_s, zero_s;
   logic [6:0]  entry_bin_s, entry_clip_s;
   logic [5:0]  tmo_inc_s;

   always_comb begin
      key_ev_s     = key_valid_i && (key_i <= 4'd11);
      is_digit_s   = key_ev_s && (key_i <= 4'd9);
      is_star_s    = key_ev_s && (key_i == 4'd10);
      is_hash_s    = key_ev_s && (key_i == 4'd11);
      zero_s       = (minute_i == 7'd0) && (second_i == 6'd0);
      entry_bin_s  = ({3'b000, entry_q[7:4]} * 7'd10) + {3'b000, entry_q[3:0]};
      entry_clip_s = (entry_bin_s > MAX_MINUTE) ? MAX_MINUTE : entry_bin_s;
      tmo_inc_s    = tmo_q + 6'd1;
   end

   // Next-state and control outputs; '*' abort issues a load of 00:00 to clear the clock.
   always_comb begin
      state_d       = state_q;
      entry_d       = entry_q;
      load_d        = 1'b0;
      load_minute_d = load_minute_q;
      pause_d       = pause_q;
      switch_d      = switch_q;
      armed_d       = armed_q;
      tmo_d         = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (is_digit_s) begin
               entry_d = {4'h0, key_i};
               state_d = S_ENTRY;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ENTRY: begin
            if (is_digit_s) begin
               entry_d = {entry_q[3:0], key_i};
            end else if (is_star_s) begin
               entry_d = 8'h00;
               state_d = S_IDLE;
            end else if (is_hash_s && (entry_q != 8'h00)) begin
               load_d        = 1'b1;
               load_minute_d = entry_clip_s;
               pause_d       = 1'b0;
               switch_d      = 1'b1;
               armed_d       = 1'b0;
               state_d       = S_RUN;
            end else begin
               state_d = S_ENTRY;
            end
         end
         S_RUN: begin
            // Arming prevents the freshly loaded clock (still 00:00) from reading as expired.
            armed_d = armed_q | !zero_s;
            if (is_star_s) begin
               load_d        = 1'b1;
               load_minute_d = 7'd0;
               entry_d       = 8'h00;
               pause_d       = 1'b1;
               switch_d      = 1'b0;
               state_d       = S_IDLE;
            end else if (armed_q && zero_s) begin
               pause_d  = 1'b1;
               switch_d = 1'b0;
               tmo_d    = 6'd0;
               state_d  = S_DONE;
            end else if (is_hash_s) begin
               pause_d  = 1'b1;
               switch_d = 1'b0;
               state_d  = S_PAUSE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_PAUSE: begin
            if (is_hash_s) begin
               pause_d  = 1'b0;
               switch_d = 1'b1;
               state_d  = S_RUN;
            end else if (is_star_s) begin
               load_d        = 1'b1;
               load_minute_d = 7'd0;
               entry_d       = 8'h00;
               pause_d       = 1'b1;
               switch_d      = 1'b0;
               state_d       = S_IDLE;
            end else begin
               state_d = S_PAUSE;
            end
         end
         S_DONE: begin
            if (key_ev_s) begin
               entry_d = 8'h00;
               state_d = S_IDLE;
            end else if (tick_1hz_i) begin
               tmo_d = tmo_inc_s;
               if ((DONE_TIMEOUT != 6'd0) && (tmo_inc_s == DONE_TIMEOUT)) begin
                  entry_d = 8'h00;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            entry_d  = 8'h00;
            pause_d  = 1'b1;
            switch_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // Display value and blink enable follow the state being entered.
   always_comb begin
      if ((state_d == S_IDLE) || (state_d == S_ENTRY)) begin
         hexx_d = {entry_d, 8'h00};
      end else begin
         hexx_d = clock_hexx_i;
      end
      if ((state_d == S_PAUSE) && (state_q == S_PAUSE)) begin
         disp_en_d = disp_en_q ^ tick_1hz_i;
`ifdef DONE_BLINK_EN
      end else if (state_d == S_DONE) begin
         disp_en_d = (state_q == S_DONE) ? (disp_en_q ^ tick_1hz_i) : 1'b0;
`endif
      end else begin
         disp_en_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         entry_q       <= 8'h00;
         load_q        <= 1'b0;
         load_minute_q <= 7'd0;
         pause_q       <= 1'b1;
         switch_q      <= 1'b0;
         hexx_q        <= 16'h0000;
         disp_en_q     <= 1'b1;
         armed_q       <= 1'b0;
         tmo_q         <= 6'd0;
         points_q      <= 4'b0100;
      end else begin
         state_q       <= state_d;
         entry_q       <= entry_d;
         load_q        <= load_d;
         load_minute_q <= load_minute_d;
         pause_q       <= pause_d;
         switch_q      <= switch_d;
         hexx_q        <= hexx_d;
         disp_en_q     <= disp_en_d;
         armed_q       <= armed_d;
         tmo_q         <= tmo_d;
         points_q      <= 4'b0100;
      end
   end

   assign load_o        = load_q;
   assign load_minute_o = load_minute_q;
   assign pause_o       = pause_q;
   assign switch_o      = switch_q;
   assign hexx_o        = hexx_q;
   assign disp_en_o     = disp_en_q;
   assign points_o      = points_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed-vector bench for countdown_ctrl (MAX_MINUTE=60, DONE_TIMEOUT=30); inputs change on negedge.
module tb_countdown_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key = 4'd0;
   logic [6:0]  minute = 7'd0;
   logic [5:0]  second = 6'd0;
   logic [15:0] clock_hexx = 16'h0000;
   logic        load, pause, switch_r, disp_en;
   logic [6:0]  load_minute;
   logic [15:0] hexx;
   logic [3:0]  points;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   countdown_ctrl #(.MAX_MINUTE(7'd60), .DONE_TIMEOUT(6'd30)) dut (
      .clk_i(clk), .rst_i(rst), .tick_1hz_i(tick), .key_valid_i(key_valid), .key_i(key),
      .minute_i(minute), .second_i(second), .clock_hexx_i(clock_hexx),
      .load_o(load), .load_minute_o(load_minute), .pause_o(pause), .switch_o(switch_r),
      .hexx_o(hexx), .disp_en_o(disp_en), .points_o(points)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // All tasks start and end on a negedge; outputs read afterwards reflect that cycle.
   task automatic press(input logic [3:0] k);
      key_valid = 1'b1; key = k;
      @(negedge clk);
      key_valid = 1'b0; key = 4'd0;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_pause", pause, 1); chk("rst_switch", switch_r, 0); chk("rst_load", load, 0);
      chk("rst_lmin", load_minute, 0); chk("rst_hexx", hexx, 16'h0000);
      chk("rst_disp", disp_en, 1); chk("rst_points", points, 4'b0100);
      rst = 1'b0;
      idle();
      chk("idle_pause", pause, 1);

      // Basic entry 2,5,'#'
      press(4'd14); chk("idle_k14", hexx, 16'h0000);
      press(4'd2);  chk("entry_2", hexx, 16'h0200);
      press(4'd5);  chk("entry_25", hexx, 16'h2500);
      clock_hexx = 16'h1234;
      press(4'd11);
      chk("go_load", load, 1); chk("go_lmin", load_minute, 25); chk("go_pause", pause, 0);
      chk("go_switch", switch_r, 1); chk("go_hexx", hexx, 16'h1234);
      minute = 7'd25; clock_hexx = 16'h2459;
      idle();
      chk("load_1clk", load, 0); chk("run_hexx", hexx, 16'h2459); chk("lmin_hold", load_minute, 25);
      press(4'd14); chk("run_k14", pause, 0);

      // Pause with blink, resume
      press(4'd11); chk("pz_pause", pause, 1); chk("pz_switch", switch_r, 0); chk("pz_disp", disp_en, 1);
      press(4'd14); chk("pz_k14", pause, 1);
      pulse_tick(); chk("blink0", disp_en, 0);
      pulse_tick(); chk("blink1", disp_en, 1);
      pulse_tick(); chk("blink2", disp_en, 0);
      press(4'd11); chk("res_pause", pause, 0); chk("res_switch", switch_r, 1); chk("res_disp", disp_en, 1);

      // Count reaches 00:00 -> DONE, then 30-tick timeout
      minute = 7'd0; clock_hexx = 16'h0000;
      idle();
      chk("done_pause", pause, 1); chk("done_switch", switch_r, 0); chk("done_disp", disp_en, 1);
      chk("done_load", load, 0);
      clock_hexx = 16'h5555;
      press(4'd14); chk("done_k14", hexx, 16'h5555);
      repeat (29) pulse_tick();
      chk("tmo29_done", hexx, 16'h5555);
      pulse_tick();
      chk("tmo30_left", (hexx != 16'h5555), 1);
      press(4'd7); chk("tmo_idle_digit", hexx, 16'h0700);

      // ENTRY edits, '*' cancel, '#' with zero entry
      press(4'd14); chk("entry_k14", hexx, 16'h0700);
      press(4'd10); chk("entry_star", hexx, 16'h0000);
      press(4'd11); chk("idle_hash", hexx, 16'h0000);
      press(4'd0);  press(4'd11);
      chk("zero_hash_load", load, 0); chk("zero_hash_pause", pause, 1);
      press(4'd1); press(4'd2); press(4'd3); chk("entry_23", hexx, 16'h2300);
      press(4'd11); chk("l23_load", load, 1); chk("l23_lmin", load_minute, 23);
      minute = 7'd23;
      idle();
      press(4'd10);
      chk("abort_load", load, 1); chk("abort_lmin", load_minute, 0); chk("abort_pause", pause, 1);
      chk("abort_switch", switch_r, 0); chk("abort_hexx", hexx, 16'h0000);

      // Clip to MAX_MINUTE
      minute = 7'd0;
      press(4'd9); press(4'd9); chk("entry_99", hexx, 16'h9900);
      press(4'd11); chk("clip_load", load, 1); chk("clip_lmin", load_minute, 60);

      // '*' and zero detect in the same clock: '*' wins
      minute = 7'd60;
      idle();
      minute = 7'd0;
      press(4'd10); chk("sz_load", load, 1); chk("sz_lmin", load_minute, 0);
      press(4'd4);  chk("sz_idle", hexx, 16'h0400);

      // '#' and zero detect in the same clock: DONE wins
      press(4'd11); chk("hz_load", load, 1);
      minute = 7'd4;
      idle();
      minute = 7'd0; clock_hexx = 16'hABCD;
      press(4'd11); chk("hz_pause", pause, 1);
      press(4'd3);  chk("hz_done_exit", hexx, 16'h0000);

      // Reset while running
      press(4'd5); press(4'd11); chk("rr_load", load, 1);
      minute = 7'd5;
      idle();
      rst = 1'b1;
      press(4'd10);
      chk("rr_load0", load, 0); chk("rr_pause", pause, 1); chk("rr_switch", switch_r, 0);
      chk("rr_lmin", load_minute, 0); chk("rr_hexx", hexx, 16'h0000); chk("rr_disp", disp_en, 1);
      rst = 1'b0;
      idle();
      chk("rr_after", pause, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
